// File: rtl/ball_motion_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ball_motion_ctrl                                             |
// | Description : Per-frame sprite motion controller with edge/paddle bounce   |
// |               and bottom-edge miss. Optional macro BALL_SPEEDUP_EN adds a  |
// |               saturating per-deflection speed boost.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ball_motion_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int RADIUS   = 8,
    parameter int START_X  = 320,
    parameter int START_Y  = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        launch,
    input  logic        launch_left,
    input  logic [3:0]  speed,
    input  logic        paddle_hit,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic [11:0] radius,
    output logic        moving,
    output logic        step_done,
    output logic        miss
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_move_wait = 2'd1;
    localparam logic [1:0] c_st_step      = 2'd2;
    localparam logic [1:0] c_st_miss      = 2'd3;

    localparam logic [12:0] c_rad_13   = 13'(RADIUS);
    localparam logic [12:0] c_scr_w_13 = 13'(SCREEN_W);
    localparam logic [12:0] c_scr_h_13 = 13'(SCREEN_H);
    localparam logic [11:0] c_rad_12   = 12'(RADIUS);
    localparam logic [11:0] c_x_max    = 12'(SCREEN_W - RADIUS - 1);
    localparam logic [11:0] c_start_x  = 12'(START_X);
    localparam logic [11:0] c_start_y  = 12'(START_Y);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_dir_left;
    logic        r_dir_up;
    logic        r_hit_pend;
    logic        r_step_done;

    logic [3:0]  w_step;
    logic [12:0] w_step_13;
    logic        w_hit;
    logic        w_dir_up_fix;
    logic [12:0] w_x_add;
    logic [12:0] w_x_fwd;
    logic [12:0] w_x_lo;
    logic [12:0] w_y_add;
    logic [12:0] w_y_fwd;
    logic [12:0] w_y_lo;
    logic [11:0] w_x_next;
    logic [11:0] w_y_next;
    logic        w_dir_left_next;
    logic        w_dir_up_next;
    logic        w_miss;

`ifdef BALL_SPEEDUP_EN
    logic [3:0] r_boost;
    logic [4:0] w_step_sum;
    logic       w_deflect;

    // Boosted step saturates at the 4-bit maximum
    assign w_step_sum = {1'b0, speed} + {1'b0, r_boost};
    assign w_step     = w_step_sum[4] ? 4'hF : w_step_sum[3:0];
    assign w_deflect  = w_hit & ~r_dir_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_boost <= 4'd0;
        end else if (r_state == c_st_miss) begin
            r_boost <= 4'd0;
        end else if ((r_state == c_st_step) && w_deflect && (r_boost != 4'hF)) begin
            r_boost <= r_boost + 4'd1;
        end
    end
`else
    assign w_step = speed;
`endif

    // Next position/direction; only consumed in STEP, sums held at 13 bits
    always_comb begin
        w_step_13       = {9'd0, w_step};
        w_hit           = r_hit_pend | paddle_hit;
        w_dir_up_fix    = r_dir_up | w_hit;
        w_x_add         = {1'b0, r_x} + w_step_13;
        w_x_fwd         = w_x_add + c_rad_13;
        w_x_lo          = c_rad_13 + w_step_13;
        w_y_add         = {1'b0, r_y} + w_step_13;
        w_y_fwd         = w_y_add + c_rad_13;
        w_y_lo          = c_rad_13 + w_step_13;
        w_x_next        = r_x;
        w_y_next        = r_y;
        w_dir_left_next = r_dir_left;
        w_dir_up_next   = w_dir_up_fix;
        w_miss          = 1'b0;

        if (r_dir_left) begin
            if ({1'b0, r_x} < w_x_lo) begin
                w_x_next        = c_rad_12;
                w_dir_left_next = 1'b0;
            end else begin
                w_x_next = r_x - {8'd0, w_step};
            end
        end else begin
            if (w_x_fwd >= c_scr_w_13) begin
                w_x_next        = c_x_max;
                w_dir_left_next = 1'b1;
            end else begin
                w_x_next = w_x_add[11:0];
            end
        end

        if (w_dir_up_fix) begin
            if ({1'b0, r_y} < w_y_lo) begin
                w_y_next      = c_rad_12;
                w_dir_up_next = 1'b0;
            end else begin
                w_y_next = r_y - {8'd0, w_step};
            end
        end else begin
            if (w_y_fwd >= c_scr_h_13) begin
                w_miss = 1'b1;
            end else begin
                w_y_next = w_y_add[11:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:      if (launch) w_next_state = c_st_move_wait;
            c_st_move_wait: if (frame_tick) w_next_state = c_st_step;
            c_st_step:      w_next_state = w_miss ? c_st_miss : c_st_move_wait;
            c_st_miss:      w_next_state = c_st_idle;
            default:        w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        moving = (r_state == c_st_move_wait) || (r_state == c_st_step);
        miss   = (r_state == c_st_miss);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= c_start_x;
            r_y         <= c_start_y;
            r_dir_left  <= 1'b0;
            r_dir_up    <= 1'b1;
            r_hit_pend  <= 1'b0;
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_x        <= c_start_x;
                    r_y        <= c_start_y;
                    r_hit_pend <= 1'b0;
                    if (launch) begin
                        r_dir_left <= launch_left;
                        r_dir_up   <= 1'b1;
                    end
                end
                c_st_move_wait: begin
                    if (paddle_hit) begin
                        r_hit_pend <= 1'b1;
                    end
                end
                c_st_step: begin
                    r_hit_pend <= 1'b0;
                    r_x        <= w_x_next;
                    r_dir_left <= w_dir_left_next;
                    if (!w_miss) begin
                        r_y         <= w_y_next;
                        r_dir_up    <= w_dir_up_next;
                        r_step_done <= 1'b1;
                    end
                end
                c_st_miss: begin
                    r_x        <= c_start_x;
                    r_y        <= c_start_y;
                    r_dir_left <= 1'b0;
                    r_dir_up   <= 1'b1;
                    r_hit_pend <= 1'b0;
                end
                default: begin
                    r_hit_pend <= 1'b0;
                end
            endcase
        end
    end

    assign x_pos     = r_x;
    assign y_pos     = r_y;
    assign radius    = c_rad_12;
    assign step_done = r_step_done;

endmodule
`default_nettype wire
